// File: rtl/nfc_flash_seq.sv
// rtl/nfc_flash_seq.sv - NAND page READ/PROGRAM command sequencer for one flash port
// Every bus cycle is one setup phase, then T_WL strobe-low phases, then T_WH strobe-high phases.
module nfc_flash_seq #(
  parameter int T_WL       = 1,
  parameter int T_WH       = 1,
  parameter int T_WB       = 4,
  parameter int PAGE_BYTES = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       op,
  input  logic [8:0] page,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic [7:0] wr_data,
  output logic       wr_pop,
  output logic [7:0] F_IO_OUT,
  output logic       F_IO_OE,
  input  logic [7:0] F_IO_IN,
  output logic       F_CLE,
  output logic       F_ALE,
  output logic       F_WEN,
  output logic       F_REN,
  input  logic       F_RB
);

  localparam int PH_LAST = T_WL + T_WH;
  localparam int PH_W    = $clog2(PH_LAST + 1);
  localparam int CNT_W   = $clog2(PAGE_BYTES + T_WB + 4);

  typedef enum logic [3:0] {
    IDLE, CMD1, ADDR, WDATA, CMD2, WAIT_B, RDATA, STAT_CMD, STAT_RD, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [8:0]        page_q, page_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rb_meta_q, rb_sync_q;
  logic              fail_q, fail_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_pop_q, wr_pop_d;
  logic [7:0]        io_out_q, io_out_d;
  logic              io_oe_q, io_oe_d;
  logic              cle_q, cle_d;
  logic              ale_q, ale_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic              ph_last, ph_sample, cnt_last_byte;
  logic              wr_cyc, rd_cyc, low_d;

  always_comb begin
    ph_last       = (ph_q == PH_W'(PH_LAST));
    ph_sample     = (ph_q == PH_W'(T_WL));
    cnt_last_byte = (cnt_q == CNT_W'(PAGE_BYTES - 1));

    state_d    = state_q;
    op_d       = op_q;
    page_d     = page_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (!(state_q inside {IDLE, WAIT_B, DONE})) begin
      ph_d = ph_last ? '0 : ph_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = CMD1;
          op_d    = op;
          page_d  = page;
          fail_d  = 1'b0;
          ph_d    = '0;
          cnt_d   = '0;
        end
      end
      CMD1: if (ph_last) state_d = ADDR;
      ADDR: begin
        if (ph_last) begin
          if (cnt_q == CNT_W'(2)) begin
            cnt_d   = '0;
            state_d = op_q ? WDATA : WAIT_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WDATA: begin
        if (ph_last) begin
          if (cnt_last_byte) begin
            cnt_d   = '0;
            state_d = CMD2;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CMD2: if (ph_last) state_d = WAIT_B;
      // Minimum T_WB wait lets the flash pull R/B low before it is trusted.
      WAIT_B: begin
        if (cnt_q != CNT_W'(T_WB - 1)) begin
          cnt_d = cnt_q + 1'b1;
        end else if (rb_sync_q) begin
          cnt_d   = '0;
          state_d = op_q ? STAT_CMD : RDATA;
        end
      end
      RDATA: begin
        if (ph_sample) begin
          rd_data_d  = F_IO_IN;
          rd_valid_d = 1'b1;
        end
        if (ph_last) begin
          if (cnt_last_byte) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STAT_CMD: if (ph_last) state_d = STAT_RD;
      STAT_RD: begin
        if (ph_sample) fail_d = F_IO_IN[0];
        if (ph_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    wr_cyc   = state_d inside {CMD1, ADDR, WDATA, CMD2, STAT_CMD};
    rd_cyc   = state_d inside {RDATA, STAT_RD};
    low_d    = (ph_d != '0) && (ph_d <= PH_W'(T_WL));
    busy_d   = !(state_d inside {IDLE, DONE});
    done_d   = (state_d == DONE);
    cle_d    = state_d inside {CMD1, CMD2, STAT_CMD};
    ale_d    = (state_d == ADDR);
    io_oe_d  = wr_cyc;
    wen_d    = !(wr_cyc && low_d);
    ren_d    = !(rd_cyc && low_d);
    wr_pop_d = (state_d == WDATA) && (ph_d == '0);

    io_out_d = io_out_q;
    case (state_d)
      CMD1: io_out_d = op_d ? 8'h80 : 8'h00;
      ADDR: begin
        case (cnt_d[1:0])
          2'd1:    io_out_d = page_d[7:0];
          2'd2:    io_out_d = {7'b0, page_d[8]};
          default: io_out_d = 8'h00;
        endcase
      end
      WDATA:    if (wr_pop_q) io_out_d = wr_data;
      CMD2:     io_out_d = 8'h10;
      STAT_CMD: io_out_d = 8'h70;
      default:  io_out_d = io_out_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      page_q     <= '0;
      ph_q       <= '0;
      cnt_q      <= '0;
      rb_meta_q  <= 1'b0;
      rb_sync_q  <= 1'b0;
      fail_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_pop_q   <= 1'b0;
      io_out_q   <= 8'h00;
      io_oe_q    <= 1'b0;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      wen_q      <= 1'b1;
      ren_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      page_q     <= page_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      rb_meta_q  <= F_RB;
      rb_sync_q  <= rb_meta_q;
      fail_q     <= fail_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_pop_q   <= wr_pop_d;
      io_out_q   <= io_out_d;
      io_oe_q    <= io_oe_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_pop   = wr_pop_q;
  assign F_IO_OUT = io_out_q;
  assign F_IO_OE  = io_oe_q;
  assign F_CLE    = cle_q;
  assign F_ALE    = ale_q;
  assign F_WEN    = wen_q;
  assign F_REN    = ren_q;

endmodule

// File: tb/tb_nfc_flash_seq.sv
// tb/tb_nfc_flash_seq.sv - scoreboard bench for nfc_flash_seq with a behavioural NAND model
module tb_nfc_flash_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       op;
  logic [8:0] page;
  logic       busy, done, fail;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] wr_data = 8'h00;
  logic       wr_pop;
  logic [7:0] F_IO_OUT;
  logic       F_IO_OE;
  logic [7:0] F_IO_IN = 8'h00;
  logic       F_CLE, F_ALE, F_WEN, F_REN;
  logic       rb = 1'b1;

  always #5 clk = ~clk;

  nfc_flash_seq #(.T_WL(1), .T_WH(1), .T_WB(4), .PAGE_BYTES(512)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .page(page),
    .busy(busy), .done(done), .fail(fail),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_data(wr_data), .wr_pop(wr_pop),
    .F_IO_OUT(F_IO_OUT), .F_IO_OE(F_IO_OE), .F_IO_IN(F_IO_IN),
    .F_CLE(F_CLE), .F_ALE(F_ALE), .F_WEN(F_WEN), .F_REN(F_REN), .F_RB(rb)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboards: bus writes as {cle, ale, io}, and read bytes.
  logic [9:0] bus_q[$];
  logic [7:0] rd_q[$];

  // Flash model state
  logic [7:0] mem [int];
  logic [7:0] status_val = 8'h00;
  logic       exp_fail   = 1'b0;
  logic [7:0] addr_b [3];
  int  m_page = 0, m_col = 0, m_busy = 0, addr_i = 0;
  bit  m_prog = 0, m_stat = 0;
  logic wen_p = 1'b1, ren_p = 1'b1, pop_p = 1'b0;
  int  wr_idx = 0;
  int  rd_cnt = 0, wr_cnt = 0, done_cnt = 0;

  function automatic logic [7:0] pat(input int pg, input int col);
    return 8'((pg * 37) ^ (col * 5) ^ (col >> 8));
  endfunction

  function automatic logic [7:0] flash_byte(input int pg, input int col);
    int k;
    k = pg * 512 + col;
    if (mem.exists(k)) return mem[k];
    return pat(pg, col);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      bus_q.delete();
      rd_q.delete();
      m_stat = 0; m_prog = 0; m_busy = 0; addr_i = 0; m_col = 0;
      rb = 1'b1; wen_p = 1'b1; ren_p = 1'b1; pop_p = 1'b0;
      wr_idx = 0; wr_data = 8'h00;
    end else begin
      if (!F_REN) check("oe_during_ren", F_IO_OE, 0);
      if (!wen_p && F_WEN) begin
        if (bus_q.size() > 0) check("bus_write", {F_CLE, F_ALE, F_IO_OUT}, bus_q.pop_front());
        else check("bus_write_unexpected", bus_q.size(), 1);
        if (F_CLE) begin
          case (F_IO_OUT)
            8'h00: begin m_prog = 0; m_stat = 0; addr_i = 0; end
            8'h80: begin m_prog = 1; m_stat = 0; addr_i = 0; end
            8'h10: begin m_busy = 20; rb = 1'b0; end
            8'h70: m_stat = 1;
            default: ;
          endcase
        end else if (F_ALE) begin
          if (addr_i < 3) addr_b[addr_i] = F_IO_OUT;
          addr_i++;
          if (addr_i == 3) begin
            m_page = {addr_b[2][0], addr_b[1]};
            m_col  = 0;
            if (!m_prog) begin m_busy = 20; rb = 1'b0; end
          end
        end else begin
          mem[m_page * 512 + m_col] = F_IO_OUT;
          m_col++;
        end
      end
      if (!ren_p && F_REN && !m_stat) m_col++;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) rb = 1'b1;
      end
      F_IO_IN = m_stat ? status_val : flash_byte(m_page, m_col);
      wen_p = F_WEN;
      ren_p = F_REN;

      if (rd_valid) begin
        rd_cnt++;
        if (rd_q.size() > 0) check("rd_data", rd_data, rd_q.pop_front());
        else check("rd_unexpected", rd_q.size(), 1);
      end
      // wr_data must stay put through the edge that ends the pop cycle.
      if (pop_p) begin
        wr_idx++;
        wr_data = 8'(wr_idx);
      end
      pop_p = wr_pop;
      if (wr_pop) wr_cnt++;
      if (done) begin
        done_cnt++;
        check("fail_at_done", fail, exp_fail);
        wr_idx = 0;
        wr_data = 8'h00;
      end
    end
  end

  task automatic push_cmds(input bit is_prog, input logic [8:0] pg, input bit ramp);
    bus_q.push_back({2'b10, is_prog ? 8'h80 : 8'h00});
    bus_q.push_back({2'b01, 8'h00});
    bus_q.push_back({2'b01, pg[7:0]});
    bus_q.push_back({2'b01, 7'b0, pg[8]});
    if (is_prog) begin
      for (int i = 0; i < 512; i++) bus_q.push_back({2'b00, 8'(i)});
      bus_q.push_back({2'b10, 8'h10});
      bus_q.push_back({2'b10, 8'h70});
    end else begin
      for (int i = 0; i < 512; i++) rd_q.push_back(ramp ? 8'(i) : pat(int'(pg), i));
    end
  endtask

  task automatic run_op(input bit is_prog, input logic [8:0] pg, input logic [7:0] stat,
                        input bit efail, input bit ramp, input int poke_at);
    int base_rd, base_wr, base_done;
    bit got_done, poked;
    base_rd = rd_cnt; base_wr = wr_cnt; base_done = done_cnt;
    got_done = 0; poked = 0;
    status_val = stat;
    exp_fail = efail;
    push_cmds(is_prog, pg, ramp);
    @(negedge clk);
    req = 1'b1; op = is_prog; page = pg;
    @(negedge clk);
    req = 1'b0;
    check("busy_after_accept", busy, 1);
    check("fail_clear_at_accept", fail, 0);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (done) begin got_done = 1; break; end
      if (poke_at > 0 && !poked && (rd_cnt - base_rd) >= poke_at) begin
        req = 1'b1; op = 1'b1; page = 9'h000; poked = 1;
      end
    end
    req = 1'b0;
    check("done_seen", got_done, 1);
    repeat (6) @(negedge clk);
    check("done_pulses", done_cnt - base_done, 1);
    check(is_prog ? "wr_pop_count" : "rd_valid_count",
          is_prog ? (wr_cnt - base_wr) : (rd_cnt - base_rd), 512);
    check("bus_q_drained", bus_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("busy_after_done", busy, 0);
    check("fail_held", fail, efail);
  endtask

  initial begin
    int base_wr;
    rst = 1'b1; req = 1'b0; op = 1'b0; page = 9'h000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cle", F_CLE, 0);
    check("rst_ale", F_ALE, 0);
    check("rst_wen", F_WEN, 1);
    check("rst_ren", F_REN, 1);
    check("rst_oe", F_IO_OE, 0);
    check("rst_io_out", F_IO_OUT, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_pop", wr_pop, 0);
    check("rst_rd_data", rd_data, 8'h00);

    run_op(1'b0, 9'h1A5, 8'h00, 1'b0, 1'b0, 0);
    run_op(1'b1, 9'd3,   8'h00, 1'b0, 1'b0, 0);
    run_op(1'b0, 9'd3,   8'h00, 1'b0, 1'b1, 0);
    run_op(1'b1, 9'd5,   8'h01, 1'b1, 1'b0, 0);
    run_op(1'b0, 9'h1A5, 8'h00, 1'b0, 1'b0, 100);

    // Abort a PROGRAM partway through the data phase.
    base_wr = wr_cnt;
    exp_fail = 1'b0;
    push_cmds(1'b1, 9'd7, 1'b0);
    @(negedge clk);
    req = 1'b1; op = 1'b1; page = 9'd7;
    @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ((wr_cnt - base_wr) >= 100) break;
      @(negedge clk);
    end
    check("abort_reached_byte100", (wr_cnt - base_wr) >= 100, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_wen", F_WEN, 1);
    check("abort_oe", F_IO_OE, 0);
    check("abort_busy", busy, 0);
    check("abort_cle", F_CLE, 0);
    check("abort_wr_pop", wr_pop, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle_done", done, 0);

    run_op(1'b0, 9'd0, 8'h00, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
